// File: rtl/i2s_slave_tx_mono.sv
// I2S slave transmitter (mono): follows external BCLK/LRCLK and shifts one word per frame out of a small FIFO.
// Optional macro I2S_SLAVE_TX_UNDERFLOW_REPEAT_EN resends the last popped word on underflow instead of zero.
module i2s_slave_tx_mono #(
  parameter int unsigned WORD_WIDTH = 24,
  parameter logic        TX_CHANNEL = 1'b0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          bclk,
  input  logic                          rst,
  input  logic                          lrclk,
  input  logic [WORD_WIDTH-1:0]         s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          sd,
  output logic                          sd_oe,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underflow,
  output logic                          underflow_sticky,
  input  logic                          clr_sticky
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned CW = 5;

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e                state_q, state_d;
  logic                  ws_q;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic                  sd_q, sd_d;
  logic                  sd_oe_q, sd_oe_d;
  logic                  underflow_q, underflow_d;
  logic                  sticky_q, sticky_d;
  logic [LW-1:0]         count_q, count_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  s_ready_q, s_ready_d;
  logic [WORD_WIDTH-1:0] mem [FIFO_DEPTH];

  logic                  ws_change, slot_start, fifo_empty, push, pop;
  logic [WORD_WIDTH-1:0] head, fallback, tx_word;

  always_comb begin
    ws_change  = (lrclk != ws_q);
    slot_start = ws_change && (lrclk == TX_CHANNEL);
    fifo_empty = (count_q == '0);
    push       = s_valid && s_ready_q;
    // Emptiness comes from registered state, so a same-edge push cannot feed this pop.
    pop        = slot_start && !fifo_empty;
    head       = mem[rd_ptr_q];
  end

`ifdef I2S_SLAVE_TX_UNDERFLOW_REPEAT_EN
  logic [WORD_WIDTH-1:0] last_q, last_d;

  always_comb begin
    last_d   = pop ? head : last_q;
    fallback = last_q;
  end

  always_ff @(posedge bclk) begin
    if (rst) last_q <= '0;
    else     last_q <= last_d;
  end
`else
  always_comb fallback = '0;
`endif

  always_comb tx_word = fifo_empty ? fallback : head;

  // Slot sequencing: edge 0 loads and drives MSB, edges 1..W-1 shift, edge W releases.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    sd_d        = 1'b0;
    sd_oe_d     = 1'b0;
    underflow_d = 1'b0;
    if (ws_change)                   bit_cnt_d = '0;
    else if (bit_cnt_q == CW'(31))   bit_cnt_d = bit_cnt_q;
    else                             bit_cnt_d = bit_cnt_q + CW'(1);

    if (slot_start) begin
      state_d     = SHIFT;
      shift_d     = {tx_word[WORD_WIDTH-2:0], 1'b0};
      sd_d        = tx_word[WORD_WIDTH-1];
      sd_oe_d     = 1'b1;
      underflow_d = fifo_empty;
    end else if (state_q == SHIFT) begin
      if (ws_change || bit_cnt_q == CW'(WORD_WIDTH - 1)) begin
        state_d = IDLE;
      end else begin
        sd_d    = shift_q[WORD_WIDTH-1];
        sd_oe_d = 1'b1;
        shift_d = {shift_q[WORD_WIDTH-2:0], 1'b0};
      end
    end

    sticky_d = underflow_d | (sticky_q & ~clr_sticky);
  end

  // FIFO bookkeeping; pointers wrap naturally because depth is a power of two.
  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d   = count_q + LW'(push) - LW'(pop);
    s_ready_d = (count_d != LW'(FIFO_DEPTH));
  end

  always_ff @(posedge bclk) begin
    ws_q <= lrclk;
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      sd_q        <= 1'b0;
      sd_oe_q     <= 1'b0;
      underflow_q <= 1'b0;
      sticky_q    <= 1'b0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      s_ready_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      sd_q        <= sd_d;
      sd_oe_q     <= sd_oe_d;
      underflow_q <= underflow_d;
      sticky_q    <= sticky_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      s_ready_q   <= s_ready_d;
    end
  end

  always_ff @(posedge bclk) begin
    if (!rst && push) mem[wr_ptr_q] <= s_data;
  end

  assign s_ready          = s_ready_q;
  assign sd               = sd_q;
  assign sd_oe            = sd_oe_q;
  assign fifo_level       = count_q;
  assign underflow        = underflow_q;
  assign underflow_sticky = sticky_q;

endmodule

// File: tb/tb_i2s_slave_tx_mono.sv
// Directed bench for i2s_slave_tx_mono: queue scoreboard of pushed words compared against captured slots.
module tb_i2s_slave_tx_mono;

  logic        bclk = 1'b0;
  logic        rst, lrclk, s_valid, clr_sticky;
  logic [23:0] s_data;
  logic        s_ready, sd, sd_oe, underflow, underflow_sticky;
  logic [2:0]  fifo_level;

  int total = 0;
  int bad   = 0;
  logic [23:0] sb [$];
  int mlevel = 0;

  always #5 bclk = ~bclk;

  i2s_slave_tx_mono #(.WORD_WIDTH(24), .TX_CHANNEL(1'b0), .FIFO_DEPTH(4)) dut (
    .bclk(bclk), .rst(rst), .lrclk(lrclk), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .sd(sd), .sd_oe(sd_oe), .fifo_level(fifo_level),
    .underflow(underflow), .underflow_sticky(underflow_sticky), .clr_sticky(clr_sticky)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge bclk);
    #1;
  endtask

  task automatic push_word(input logic [23:0] w);
    logic acc;
    s_valid = 1'b1;
    s_data  = w;
    acc     = (mlevel < 4);
    tick();
    s_valid = 1'b0;
    if (acc) begin
      sb.push_back(w);
      mlevel++;
    end
  endtask

  function automatic logic [23:0] sb_pop();
    logic [23:0] v;
    v = 'x;
    if (sb.size() > 0) v = sb.pop_front();
    return v;
  endfunction

  // One 64-bclk frame: lrclk low for 32 edges then high for 32; edge index 0 is the slot start.
  task automatic run_frame(input bit do_push, input logic [23:0] pw,
                           output logic [23:0] word, output int oe_cnt,
                           output int first_idx, output int ufl_cnt, output int bad_hi);
    word = '0; oe_cnt = 0; first_idx = -1; ufl_cnt = 0; bad_hi = 0;
    for (int i = 0; i < 64; i++) begin
      lrclk = (i < 32) ? 1'b0 : 1'b1;
      if (do_push && i == 0) begin
        s_valid = 1'b1;
        s_data  = pw;
      end else begin
        s_valid = 1'b0;
      end
      tick();
      if (sd_oe === 1'b1) begin
        word = {word[22:0], sd};
        oe_cnt++;
        if (first_idx < 0) first_idx = i;
        if (i >= 32) bad_hi++;
      end else if (sd !== 1'b0) begin
        bad_hi++;
      end
      if (underflow === 1'b1) ufl_cnt++;
    end
    s_valid = 1'b0;
  endtask

  initial begin
    logic [23:0] w;
    logic [23:0] exp_w;
    int oe, fi, uf, bh;

    rst = 1'b1; lrclk = 1'b1; s_valid = 1'b0; s_data = '0; clr_sticky = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_sd", 32'(sd), 32'd0);
    check("rst_sd_oe", 32'(sd_oe), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    check("rst_sticky", 32'(underflow_sticky), 32'd0);

    // Basic slot
    push_word(24'hA50F3C);
    check("basic_level_after_push", 32'(fifo_level), 32'd1);
    run_frame(1'b0, '0, w, oe, fi, uf, bh); mlevel--;
    check("basic_word", 32'(w), 32'(sb_pop()));
    check("basic_oe_cnt", 32'(oe), 32'd24);
    check("basic_first_edge", 32'(fi), 32'd0);
    check("basic_no_stray", 32'(bh), 32'd0);
    check("basic_no_underflow", 32'(uf), 32'd0);
    check("basic_level_after", 32'(fifo_level), 32'd0);

    // Loopback pair, in order
    push_word(24'h800001);
    push_word(24'h7FFFFF);
    check("pair_level", 32'(fifo_level), 32'd2);
    for (int k = 0; k < 2; k++) begin
      run_frame(1'b0, '0, w, oe, fi, uf, bh); mlevel--;
      check("pair_word", 32'(w), 32'(sb_pop()));
      check("pair_oe_cnt", 32'(oe), 32'd24);
    end

    // FIFO full with no frames running
    push_word(24'h111111);
    push_word(24'h222222);
    push_word(24'h333333);
    check("full_ready_3", 32'(s_ready), 32'd1);
    push_word(24'h444444);
    check("full_ready_4", 32'(s_ready), 32'd0);
    check("full_level_4", 32'(fifo_level), 32'd4);
    push_word(24'h555555);
    check("full_level_5th", 32'(fifo_level), 32'd4);
    run_frame(1'b0, '0, w, oe, fi, uf, bh); mlevel--;
    check("full_word0", 32'(w), 32'(sb_pop()));
    check("full_ready_after_slot", 32'(s_ready), 32'd1);
    check("full_level_after_slot", 32'(fifo_level), 32'd3);
    for (int k = 0; k < 3; k++) begin
      run_frame(1'b0, '0, w, oe, fi, uf, bh); mlevel--;
      check("full_drain_word", 32'(w), 32'(sb_pop()));
    end

    // Underflow after a real transmission
    push_word(24'h123456);
    run_frame(1'b0, '0, w, oe, fi, uf, bh); mlevel--;
    check("ufl_prev_word", 32'(w), 32'(sb_pop()));
    check("ufl_prev_no_pulse", 32'(uf), 32'd0);
    run_frame(1'b0, '0, w, oe, fi, uf, bh);
`ifdef I2S_SLAVE_TX_UNDERFLOW_REPEAT_EN
    exp_w = 24'h123456;
`else
    exp_w = 24'h000000;
`endif
    check("ufl_word", 32'(w), 32'(exp_w));
    check("ufl_pulse_cnt", 32'(uf), 32'd1);
    check("ufl_oe_cnt", 32'(oe), 32'd24);
    check("ufl_sticky", 32'(underflow_sticky), 32'd1);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    check("ufl_sticky_clr", 32'(underflow_sticky), 32'd0);

    // Push into empty FIFO on the slot-start edge: not visible, kept for next slot
    run_frame(1'b1, 24'h5EED42, w, oe, fi, uf, bh);
    check("edgepush_word", 32'(w), 32'(exp_w));
    check("edgepush_ufl", 32'(uf), 32'd1);
    check("edgepush_level", 32'(fifo_level), 32'd1);
    run_frame(1'b0, '0, w, oe, fi, uf, bh);
    check("edgepush_next_word", 32'(w), 32'h5EED42);
    check("edgepush_next_ufl", 32'(uf), 32'd0);

    // Short frame: lrclk toggles after 12 edges
    push_word(24'hC3A55A);
    w = '0; oe = 0; bh = 0;
    for (int i = 0; i < 44; i++) begin
      lrclk = (i < 12) ? 1'b0 : 1'b1;
      tick();
      if (sd_oe === 1'b1) begin
        w = {w[22:0], sd};
        if (i < 12) oe++; else bh++;
      end
      if (i == 12) check("short_oe_drop", 32'(sd_oe), 32'd0);
    end
    void'(sb_pop()); mlevel--;
    check("short_oe_cnt", 32'(oe), 32'd12);
    check("short_other_half", 32'(bh), 32'd0);
    check("short_bits", 32'(w[11:0]), 32'hC3A);

    // Reset mid-slot at edge 10
    push_word(24'hFEDCBA);
    for (int i = 0; i < 10; i++) begin
      lrclk = 1'b0;
      tick();
    end
    check("rstmid_oe_before", 32'(sd_oe), 32'd1);
    rst = 1'b1;
    tick();
    check("rstmid_oe_drop", 32'(sd_oe), 32'd0);
    tick();
    rst = 1'b0;
    sb.delete(); mlevel = 0;
    oe = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sd_oe !== 1'b0) oe++;
    end
    check("rstmid_no_drive", 32'(oe), 32'd0);
    check("rstmid_level", 32'(fifo_level), 32'd0);
    check("rstmid_ready", 32'(s_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
